// File: rtl/spi_lcd_monitor.sv
// Passive observer of the 4-wire LCD SPI bus: deserialises words, assembles RAMWR pixels, keeps stats and error flags.
// Latency: word_valid/pixel_valid appear SYNC_STAGES+2 clk cycles after the raw sampling edge of a word's last bit.
// Backpressure: none; the monitor never stalls the bus and every output is a pulse or a level.
module spi_lcd_monitor #(
    parameter int unsigned          WORD_BITS   = 8,
    parameter int unsigned          SAMPLE_EDGE = 0,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          PIXEL_WORDS = 2,
    parameter logic [WORD_BITS-1:0] RAMWR_CMD   = 8'h2C,
    parameter int unsigned          CNT_W       = 24
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             lcd_resetn,
    input  logic                             lcd_clk,
    input  logic                             lcd_cs,
    input  logic                             lcd_rs,
    input  logic                             lcd_data,
    input  logic                             clear,
    output logic                             word_valid,
    output logic [WORD_BITS-1:0]             word_data,
    output logic                             word_is_data,
    output logic                             pixel_valid,
    output logic [WORD_BITS*PIXEL_WORDS-1:0] pixel_data,
    output logic                             in_ramwr,
    output logic [CNT_W-1:0]                 cmd_count,
    output logic [CNT_W-1:0]                 data_count,
    output logic [CNT_W-1:0]                 pixel_count,
    output logic                             err_frame,
    output logic                             err_pixel
);

    localparam int unsigned PW    = WORD_BITS * PIXEL_WORDS;
    localparam int unsigned BCW   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned PCW   = (PIXEL_WORDS > 1) ? $clog2(PIXEL_WORDS) : 1;
    localparam int unsigned LAST  = SYNC_STAGES - 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WORD_BITS - 1);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXEL_WORDS - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Bus synchronizers plus one extra flop on clk and cs for edge detection
    logic [SYNC_STAGES-1:0] sclk_q, scs_q, srs_q, sdat_q, srstn_q;
    logic                   clk_prev_q, cs_prev_q;

    // Registered sample / cs-rise events
    logic ev_q, ev_dat_q, ev_rs_q, cs_rise_q;
    logic ev_d, cs_rise_d;

    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 word_valid_q, word_valid_d;
    logic [WORD_BITS-1:0] word_data_q, word_data_d;
    logic                 word_is_data_q, word_is_data_d;
    state_t               state_q, state_d;
    logic [PCW-1:0]       pix_cnt_q, pix_cnt_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic                 pixel_valid_q, pixel_valid_d;
    logic [PW-1:0]        pixel_data_q, pixel_data_d;
    logic [CNT_W-1:0]     cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]     data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0]     pix_count_q, pix_count_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_pixel_q, err_pixel_d;

    logic                 clk_now, cs_now, panel_run, edge_sel;
    logic [WORD_BITS-1:0] word_nxt;
    logic [PW-1:0]        pix_nxt;
    logic                 word_done;

    assign clk_now   = sclk_q[LAST];
    assign cs_now    = scs_q[LAST];
    assign panel_run = srstn_q[LAST];
    assign edge_sel  = (SAMPLE_EDGE != 0) ? (~clk_now & clk_prev_q) : (clk_now & ~clk_prev_q);
    assign ev_d      = edge_sel & ~cs_now & panel_run;
    assign cs_rise_d = cs_now & ~cs_prev_q;

    always_comb begin
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        word_valid_d   = 1'b0;
        word_data_d    = word_data_q;
        word_is_data_d = word_is_data_q;
        state_d        = state_q;
        pix_cnt_d      = pix_cnt_q;
        acc_d          = acc_q;
        pixel_valid_d  = 1'b0;
        pixel_data_d   = pixel_data_q;
        cmd_cnt_d      = cmd_cnt_q;
        data_cnt_d     = data_cnt_q;
        pix_count_d    = pix_count_q;
        err_frame_d    = err_frame_q;
        err_pixel_d    = err_pixel_q;
        word_nxt       = {shift_q[WORD_BITS-2:0], ev_dat_q};
        pix_nxt        = PW'({acc_q, word_nxt});
        word_done      = 1'b0;

        // Panel in reset wins; a cs release outranks a coincident sample
        if (!panel_run) begin
            bit_cnt_d = '0;
            pix_cnt_d = '0;
            state_d   = S_IDLE;
        end else if (cs_rise_q) begin
            if (bit_cnt_q != '0) begin
                err_frame_d = 1'b1;
            end
            bit_cnt_d = '0;
        end else if (ev_q) begin
            shift_d = word_nxt;
            if (bit_cnt_q == BIT_LAST) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (word_done) begin
            word_valid_d   = 1'b1;
            word_data_d    = word_nxt;
            word_is_data_d = ev_rs_q;
            if (ev_rs_q) begin
                if (!(&data_cnt_q)) begin
                    data_cnt_d = data_cnt_q + 1'b1;
                end
                if (state_q == S_STREAM) begin
                    acc_d = pix_nxt;
                    if (pix_cnt_q == PIX_LAST) begin
                        pixel_valid_d = 1'b1;
                        pixel_data_d  = pix_nxt;
                        pix_cnt_d     = '0;
                        if (!(&pix_count_q)) begin
                            pix_count_d = pix_count_q + 1'b1;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end else begin
                if (!(&cmd_cnt_q)) begin
                    cmd_cnt_d = cmd_cnt_q + 1'b1;
                end
                if ((state_q == S_STREAM) && (pix_cnt_q != '0)) begin
                    err_pixel_d = 1'b1;
                end
                pix_cnt_d = '0;
                state_d   = (word_nxt == RAMWR_CMD) ? S_STREAM : S_IDLE;
            end
        end

        if (clear) begin
            cmd_cnt_d   = '0;
            data_cnt_d  = '0;
            pix_count_d = '0;
            err_frame_d = 1'b0;
            err_pixel_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q         <= '0;
            scs_q          <= '0;
            srs_q          <= '0;
            sdat_q         <= '0;
            srstn_q        <= '0;
            clk_prev_q     <= 1'b0;
            cs_prev_q      <= 1'b0;
            ev_q           <= 1'b0;
            ev_dat_q       <= 1'b0;
            ev_rs_q        <= 1'b0;
            cs_rise_q      <= 1'b0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            word_valid_q   <= 1'b0;
            word_data_q    <= '0;
            word_is_data_q <= 1'b0;
            state_q        <= S_IDLE;
            pix_cnt_q      <= '0;
            acc_q          <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_data_q   <= '0;
            cmd_cnt_q      <= '0;
            data_cnt_q     <= '0;
            pix_count_q    <= '0;
            err_frame_q    <= 1'b0;
            err_pixel_q    <= 1'b0;
        end else begin
            sclk_q         <= {sclk_q[SYNC_STAGES-2:0], lcd_clk};
            scs_q          <= {scs_q[SYNC_STAGES-2:0], lcd_cs};
            srs_q          <= {srs_q[SYNC_STAGES-2:0], lcd_rs};
            sdat_q         <= {sdat_q[SYNC_STAGES-2:0], lcd_data};
            srstn_q        <= {srstn_q[SYNC_STAGES-2:0], lcd_resetn};
            clk_prev_q     <= clk_now;
            cs_prev_q      <= cs_now;
            ev_q           <= ev_d;
            ev_dat_q       <= sdat_q[LAST];
            ev_rs_q        <= srs_q[LAST];
            cs_rise_q      <= cs_rise_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            word_valid_q   <= word_valid_d;
            word_data_q    <= word_data_d;
            word_is_data_q <= word_is_data_d;
            state_q        <= state_d;
            pix_cnt_q      <= pix_cnt_d;
            acc_q          <= acc_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_data_q   <= pixel_data_d;
            cmd_cnt_q      <= cmd_cnt_d;
            data_cnt_q     <= data_cnt_d;
            pix_count_q    <= pix_count_d;
            err_frame_q    <= err_frame_d;
            err_pixel_q    <= err_pixel_d;
        end
    end

    assign word_valid   = word_valid_q;
    assign word_data    = word_data_q;
    assign word_is_data = word_is_data_q;
    assign pixel_valid  = pixel_valid_q;
    assign pixel_data   = pixel_data_q;
    assign in_ramwr     = (state_q == S_STREAM);
    assign cmd_count    = cmd_cnt_q;
    assign data_count   = data_cnt_q;
    assign pixel_count  = pix_count_q;
    assign err_frame    = err_frame_q;
    assign err_pixel    = err_pixel_q;

endmodule
